regfile_mp: RTL

//  Parametrised multi-read-port register file for the datapath; successor to the single 32x32 2R1W file.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_scrub_fsm.sv | 70 +++++++
 rtl/regfile_mp.sv | 85 ++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port register file.
package regfile_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCRUB,
    DONE
  } rf_state_t;

  localparam int DW_DEF    = 32;
  localparam int DEPTH_DEF = 32;

endpackage

// File: rtl/regfile_scrub_fsm.sv
// Scrub sequencer for regfile_mp: walks every writable entry once, clearing it,
// and blocks/flags user writes while active.
module regfile_scrub_fsm
  import regfile_pkg::*;
#(
  parameter int DEPTH    = DEPTH_DEF,
  parameter int AW       = $clog2(DEPTH),
  parameter bit ZERO_REG = 1'b1
) (
  input  logic          CLK,
  input  logic          Reset_L,
  input  logic          clr_req,
  input  logic          wr_en,
  output logic          clr_busy,
  output logic          clr_done,
  output logic          wr_drop,
  output logic          scrub_we,
  output logic [AW-1:0] scrub_addr,
  output logic          wr_block
);

  localparam logic [AW-1:0] PTR_START = ZERO_REG ? AW'(1) : '0;
  localparam logic [AW-1:0] PTR_LAST  = AW'(DEPTH - 1);

  rf_state_t     state;
  rf_state_t     state_nxt;
  logic [AW-1:0] ptr;

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Pointer holds at the last entry on the DONE transition instead of wrapping.
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      ptr     <= '0;
      wr_drop <= 1'b0;
    end else begin
      wr_drop <= (state == SCRUB) && wr_en;
      if ((state == IDLE) && clr_req) begin
        ptr <= PTR_START;
      end else if ((state == SCRUB) && (ptr != PTR_LAST)) begin
        ptr <= ptr + AW'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (clr_req) state_nxt = SCRUB;
      SCRUB:   if (ptr == PTR_LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    clr_busy   = (state == SCRUB);
    clr_done   = (state == DONE);
    scrub_we   = (state == SCRUB);
    wr_block   = (state == SCRUB);
    scrub_addr = ptr;
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with optional zero entry and scrub engine.
// Define REGFILE_BYPASS_EN for write-through forwarding on same-cycle read/write collisions.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int AW       = $clog2(DEPTH),
  parameter int NUM_RD   = 2,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                 CLK,
  input  logic                 Reset_L,
  input  logic [NUM_RD*AW-1:0] rd_addr,
  output logic [NUM_RD*DW-1:0] rd_data,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [DW-1:0]        wr_data,
  input  logic                 clr_req,
  output logic                 clr_busy,
  output logic                 clr_done,
  output logic                 wr_drop
);

  logic [DW-1:0] mem [DEPTH];
  logic          scrub_we;
  logic [AW-1:0] scrub_addr;
  logic          wr_block;
  logic          wr_accept;

  regfile_scrub_fsm #(
    .DEPTH    (DEPTH),
    .AW       (AW),
    .ZERO_REG (ZERO_REG)
  ) u_scrub (
    .CLK        (CLK),
    .Reset_L    (Reset_L),
    .clr_req    (clr_req),
    .wr_en      (wr_en),
    .clr_busy   (clr_busy),
    .clr_done   (clr_done),
    .wr_drop    (wr_drop),
    .scrub_we   (scrub_we),
    .scrub_addr (scrub_addr),
    .wr_block   (wr_block)
  );

  always_comb begin
    wr_accept = wr_en && !wr_block && !(ZERO_REG && (wr_addr == '0));
  end

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (scrub_we) begin
      mem[scrub_addr] <= '0;
    end else if (wr_accept) begin
      mem[wr_addr] <= wr_data;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [AW-1:0] addr;
    logic [DW-1:0] word;

    assign addr = rd_addr[p*AW +: AW];

    always_comb begin
      word = mem[addr];
`ifdef REGFILE_BYPASS_EN
      if (wr_accept && (addr == wr_addr)) begin
        word = wr_data;
      end
`endif
      if (ZERO_REG && (addr == '0)) begin
        word = '0;
      end
    end

    assign rd_data[p*DW +: DW] = word;
  end

endmodule
